// File: rtl/cpu_pkg.sv
// Shared CPU datapath package: default bus width and the canonical word type.
package cpu_pkg;

    localparam int DEFAULT_WIDTH = 64;

    typedef logic [63:0] word_t;

endpackage : cpu_pkg

// File: rtl/mux2_1.sv
// Single-bit 2:1 multiplexer built from an inverter and AND/OR gates.
// y = s ? b : a
module mux2_1 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);

    logic s_n_s;

    assign s_n_s = ~s;
    assign y     = (a & s_n_s) | (b & s);

endmodule : mux2_1

// File: rtl/bus_mux4_1.sv
// Bus-wide 4:1 multiplexer. out is a zero-latency combinational selection
// of in[sel]; out_q is the same word registered on the rising clock edge,
// cleared asynchronously while rst_n is low. out never depends on clk/rst_n,
// so parents can cascade out through several levels without added latency.
module bus_mux4_1
    import cpu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0][WIDTH-1:0] in,
    input  logic [1:0]            sel,
    output logic [WIDTH-1:0]      out,
    output logic [WIDTH-1:0]      out_q
);

    // Level-1 results: lvl1_a_s picks between words 0/1, lvl1_b_s between 2/3.
    logic [WIDTH-1:0] lvl1_a_s;
    logic [WIDTH-1:0] lvl1_b_s;

    // Two-level tree of single-bit muxes, one column per data bit so each
    // output bit only ever sees the same bit position of the four words.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        mux2_1 u_lvl1_a (
            .a (in[0][b]),
            .b (in[1][b]),
            .s (sel[0]),
            .y (lvl1_a_s[b])
        );

        mux2_1 u_lvl1_b (
            .a (in[2][b]),
            .b (in[3][b]),
            .s (sel[0]),
            .y (lvl1_b_s[b])
        );

        mux2_1 u_lvl2 (
            .a (lvl1_a_s[b]),
            .b (lvl1_b_s[b]),
            .s (sel[1]),
            .y (out[b])
        );
    end : g_bit

    // Registered copy of the selected word, cleared immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= {WIDTH{1'b0}};
        end else begin
            out_q <= out;
        end
    end

endmodule : bus_mux4_1

// File: tb/tb_bus_mux4_1.sv
// Directed self-checking bench for bus_mux4_1: an 8-bit instance, a 16:1
// cascade of five 8-bit instances, and a 64-bit walking-ones smoke test.
// Expected values are pushed to a scoreboard queue when stimulus is applied
// and popped when the corresponding DUT output is sampled.
module tb_bus_mux4_1;

    logic clk = 1'b0;
    logic rst_n;

    // 8-bit instance
    logic [3:0][7:0]  in8;
    logic [1:0]       sel8;
    logic [7:0]       out8;
    logic [7:0]       outq8;

    // 16:1 cascade built from five 8-bit instances
    logic [15:0][7:0] in16;
    logic [3:0]       sel16;
    logic [3:0][7:0]  leaf_out;
    logic [3:0][7:0]  leaf_q;
    logic [7:0]       out16;
    logic [7:0]       out16_q;

    // 64-bit instance
    logic [3:0][63:0] in64;
    logic [1:0]       sel64;
    logic [63:0]      out64;
    logic [63:0]      outq64;

    int passed = 0;
    int total  = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    bus_mux4_1 #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in8),
        .sel   (sel8),
        .out   (out8),
        .out_q (outq8)
    );

    for (genvar i = 0; i < 4; i++) begin : g_leaf
        bus_mux4_1 #(.WIDTH(8)) u_leaf (
            .clk   (clk),
            .rst_n (rst_n),
            .in    (in16[4*i+3 -: 4]),
            .sel   (sel16[1:0]),
            .out   (leaf_out[i]),
            .out_q (leaf_q[i])
        );
    end : g_leaf

    bus_mux4_1 #(.WIDTH(8)) u_root (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (leaf_out),
        .sel   (sel16[3:2]),
        .out   (out16),
        .out_q (out16_q)
    );

    bus_mux4_1 #(.WIDTH(64)) u_dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in64),
        .sel   (sel64),
        .out   (out64),
        .out_q (outq64)
    );

    task automatic push(input logic [63:0] exp_v);
        sb.push_back(exp_v);
    endtask

    task automatic check_pop(input string tag, input logic [63:0] obs);
        logic [63:0] exp_v;
        total++;
        if (sb.size() == 0) begin
            $error("FAIL %s scoreboard empty, observed %h", tag, obs);
        end else begin
            exp_v = sb.pop_front();
            assert (obs === exp_v) passed++;
            else $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    initial begin
        logic [7:0]       t1 [4];
        logic [7:0]       t2 [4];
        logic [3:0][7:0]  base8;
        logic [15:0][7:0] base16;
        logic [63:0]      w1;

        t1 = '{8'h80, 8'h98, 8'hFF, 8'hDE};
        t2 = '{8'h7F, 8'h67, 8'h00, 8'h21};
        base8  = {8'hDE, 8'hFF, 8'h98, 8'h80};
        base16 = {8'hCA, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'hBC, 8'h9A,
                  8'h78, 8'h56, 8'h34, 8'h12, 8'hDE, 8'hFF, 8'h98, 8'h80};

        rst_n = 1'b0;
        in8   = base8;
        sel8  = 2'd0;
        in16  = '0;
        sel16 = 4'd0;
        in64  = '0;
        sel64 = 2'd0;

        // Reset state
        #2;
        push(64'h0);
        check_pop("reset_outq", 64'(outq8));

        // Test 1: sel sweep
        for (int s = 0; s < 4; s++) begin
            sel8 = 2'(s);
            push(64'(t1[s]));
            #10;
            check_pop($sformatf("t1_sel%0d", s), 64'(out8));
        end

        // Test 2: inverted inputs
        in8 = ~base8;
        for (int s = 0; s < 4; s++) begin
            sel8 = 2'(s);
            push(64'(t2[s]));
            #10;
            check_pop($sformatf("t2_sel%0d", s), 64'(out8));
        end

        // Test 3: held in reset, then release
        in8  = base8;
        sel8 = 2'd2;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            push(64'h0);
            check_pop($sformatf("t3_rst_outq%0d", k), 64'(outq8));
            push(64'hFF);
            check_pop($sformatf("t3_rst_out%0d", k), 64'(out8));
        end
        @(negedge clk);
        rst_n = 1'b1;
        push(64'hFF);
        @(posedge clk); #1;
        check_pop("t3_release_outq", 64'(outq8));

        // Test 4: sel change between edges
        @(negedge clk);
        sel8 = 2'd1;
        push(64'h98);
        @(posedge clk); #1;
        check_pop("t4_outq_sel1", 64'(outq8));
        @(negedge clk);
        sel8 = 2'd3;
        #1;
        push(64'hDE);
        check_pop("t4_out_sel3", 64'(out8));
        push(64'h98);
        check_pop("t4_outq_hold", 64'(outq8));
        push(64'hDE);
        @(posedge clk); #1;
        check_pop("t4_outq_sel3", 64'(outq8));

        // Test 5: asynchronous reset mid-cycle
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        push(64'h0);
        check_pop("t5_async_outq", 64'(outq8));
        push(64'hDE);
        check_pop("t5_out_kept", 64'(out8));
        @(negedge clk);
        rst_n = 1'b1;

        // Test 6: 16:1 cascade, normal then inverted
        for (int p = 0; p < 2; p++) begin
            in16 = (p == 0) ? base16 : ~base16;
            for (int s = 0; s < 16; s++) begin
                sel16 = 4'(s);
                push(64'(in16[s]));
                #2;
                check_pop($sformatf("t6_p%0d_sel%0d", p, s), 64'(out16));
            end
        end
        @(negedge clk);
        sel16 = 4'd9;
        push(64'(in16[9]));
        push(64'(in16[8 + 1]));
        @(posedge clk); #1;
        check_pop("t6_root_outq", 64'(out16_q));
        check_pop("t6_leaf2_outq", 64'(leaf_q[2]));

        // WIDTH=64 walking ones per word
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 64; b++) begin
                w1 = 64'h1 << b;
                in64 = '0;
                in64[w] = w1;
                for (int s = 0; s < 4; s++) begin
                    sel64 = 2'(s);
                    push((s == w) ? w1 : 64'h0);
                    #1;
                    check_pop($sformatf("w64_w%0d_b%0d_s%0d", w, b, s), out64);
                end
            end
        end
        @(negedge clk);
        in64  = {64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF,
                 64'hA5A5_5A5A_F0F0_0F0F, 64'h8000_0000_0000_0001};
        sel64 = 2'd2;
        push(64'h0123_4567_89AB_CDEF);
        @(posedge clk); #1;
        check_pop("w64_outq", outq64);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_bus_mux4_1
